trap_controller: RTL and testbench
==================================

// Module: trap_controller
// PURPOSE
//  Sequences machine-mode trap entry (ECALL, illegal instruction, external interrupt) for the 5-stage pipeline.
//  Detects the trap in EX, squashes younger instructions and freezes fetch, then drains MEM/WB.
//  Writes mepc, then mcause, through the CSR file's write port, clears mstatus.MIE, and redirects the PC to mtvec.
//  Sits beside the hazard unit; its flush/stall outputs are OR-ed with the hazard unit's.
// PARAMETERS
//  XLEN          32  datapath / PC width
//  DRAIN_CYCLES  2   cycles waited for MEM and WB instructions to retire before CSR writes (>=1)
// PORTS
//  i_clk            in   1     clock; the block uses this single clock
//  i_rst_n          in   1     reset, asynchronous, active-low
//  i_valid_e        in   1     EX holds a real (non-bubble) instruction
//  i_ecall_e        in   1     EX instruction is ECALL
//  i_illegal_e      in   1     EX instruction decoded illegal
//  i_mret_e         in   1     EX instruction is MRET
//  i_ext_irq        in   1     external interrupt request, level
//  i_mie            in   1     mstatus.MIE
//  i_pc_e           in   XLEN  PC of the EX instruction
//  i_mtvec          in   XLEN  current mtvec (direct mode only)
//  o_if_id_flush    out  1     flush the IF/ID register
//  o_id_ex_flush    out  1     flush the ID/EX register
//  o_ex_mem_flush   out  1     squash the trapping EX instruction
//  o_pc_stall       out  1     hold the PC
//  o_pc_redirect    out  1     load o_pc_target into the PC this cycle
//  o_pc_target      out  XLEN  trap vector
//  o_csr_we         out  1     CSR write strobe (takes priority over pipeline CSR writes)
//  o_csr_addr       out  12    CSR address
//  o_csr_wdata      out  XLEN  CSR write data
//  o_mie_clear      out  1     one-cycle pulse: MPIE<=MIE, MIE<=0
//  o_busy           out  1     controller is not IDLE
// BEHAVIOUR
//  - Reset: state=IDLE, counter=0, epc/cause registers=0, every output 0.
//  - Reset asserted mid-sequence aborts the sequence. Partially written CSRs are not rolled back.
//  - Trap request while IDLE: take = i_valid_e & (i_illegal_e | i_ecall_e | (i_ext_irq & i_mie & ~i_mret_e)).
//  - Priority: illegal (cause 2) > ecall (cause 11) > interrupt (cause 32'h8000_000B).
//  - MRET in EX together with a pending interrupt: MRET wins; the interrupt is re-evaluated once IDLE resumes.
//  - Cycle T (detect, still in IDLE):
//    - latch epc = i_pc_e and the encoded cause;
//    - assert o_ex_mem_flush, o_id_ex_flush, o_if_id_flush and o_pc_stall combinationally;
//    - next state DRAIN, counter = DRAIN_CYCLES-1.
//  - DRAIN:
//    - stall the PC and flush IF/ID and ID/EX every cycle;
//    - leave MEM/WB untouched;
//    - decrement the counter and go to WR_EPC when it reaches 0.
//  - WR_EPC:    o_csr_we=1, o_csr_addr=mepc 12'h341, o_csr_wdata=epc.
//  - WR_CAUSE:  o_csr_we=1, o_csr_addr=mcause 12'h342, o_csr_wdata=cause.
//  - WR_STATUS: o_mie_clear=1.
//  - REDIRECT:  o_pc_redirect=1, o_pc_target = {i_mtvec[XLEN-1:2],2'b00}, o_pc_stall=0, flushes=1; next IDLE.
//  - Stall and flush stay asserted from WR_EPC through WR_STATUS.
//  - Latency: redirect in cycle T+DRAIN_CYCLES+4; the handler's first fetch is in T+DRAIN_CYCLES+5.
//  - Trap inputs are ignored while o_busy=1. The irq is a level and is re-sampled after IDLE is reached.
//  - After REDIRECT, MIE=0, so a still-high i_ext_irq cannot retrigger.
//  - In IDLE with no take, all outputs are 0 (o_pc_target = 0).
//  - o_csr_addr and o_csr_wdata are 0 whenever o_csr_we=0.
// STRUCTURE
//  - Constants.vh gains:
//    - `mepc / `mcause addresses (reuse `mepc where present);
//    - cause codes CAUSE_ILLEGAL, CAUSE_ECALL_M, CAUSE_MEXT_IRQ;
//    - 3-bit state encodings TRAP_IDLE, TRAP_DRAIN, TRAP_WR_EPC, TRAP_WR_CAUSE, TRAP_WR_STATUS, TRAP_REDIRECT.
//  - One sub-module, trap_cause_prio: combinational priority encoder giving take and cause[XLEN-1:0].
//  - The FSM, counter and epc/cause registers live in the top.
// TESTING
//  1. i_ecall_e=1, i_valid_e=1, i_pc_e=32'h0000_0040, i_mtvec=32'h0000_0101, DRAIN_CYCLES=2
//     -> T+3 writes 341<=0x40; T+4 writes 342<=0xB; T+5 pulses o_mie_clear; T+6 redirects with target 0x100.
//  2. i_illegal_e=1 and i_ecall_e=1 in the same cycle -> mcause write data 0x2.
//  3. i_ext_irq=1, i_mie=1, i_mret_e=1 -> no take. The next cycle (mret gone, irq still high) takes cause 0x8000_000B.
//  4. i_ext_irq=1, i_mie=0 for 20 cycles -> o_busy stays 0 and all outputs stay 0.
//  5. i_ecall_e pulses again during DRAIN -> ignored; exactly one mepc write and one mcause write occur.
//  6. i_rst_n dropped in WR_CAUSE -> all outputs 0 immediately (async); after release, state is IDLE and o_busy=0.

Source files
------------

// File: rtl/trap_controller_pkg.sv
// Shared constants and state encoding for machine-mode trap entry.
// CSR addresses, exception codes and the trap sequencer states.
package trap_controller_pkg;

  localparam logic [11:0] CSR_MEPC   = 12'h341;
  localparam logic [11:0] CSR_MCAUSE = 12'h342;

  localparam logic [3:0] CAUSE_ILLEGAL  = 4'd2;
  localparam logic [3:0] CAUSE_ECALL_M  = 4'd11;
  localparam logic [3:0] CAUSE_MEXT_IRQ = 4'd11;

  typedef enum logic [2:0] {
    TRAP_IDLE      = 3'd0,
    TRAP_DRAIN     = 3'd1,
    TRAP_WR_EPC    = 3'd2,
    TRAP_WR_CAUSE  = 3'd3,
    TRAP_WR_STATUS = 3'd4,
    TRAP_REDIRECT  = 3'd5
  } trap_state_e;

  // States that keep the front end frozen
  function automatic logic holds_pipe(
    input trap_state_e s
  );
    return (s == TRAP_DRAIN)    ||
           (s == TRAP_WR_EPC)   ||
           (s == TRAP_WR_CAUSE) ||
           (s == TRAP_WR_STATUS);
  endfunction

endpackage

// File: rtl/trap_controller_cause_prio.sv
// Trap request priority encoder.
// Illegal beats ECALL beats the external interrupt; MRET masks the irq.
module trap_controller_cause_prio
  import trap_controller_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            i_valid_e,
  input  logic            i_ecall_e,
  input  logic            i_illegal_e,
  input  logic            i_mret_e,
  input  logic            i_ext_irq,
  input  logic            i_mie,
  output logic            o_take,
  output logic [XLEN-1:0] o_cause
);

  logic sel_ill;
  logic sel_ecall;
  logic sel_irq;
  logic irq_ok;

  assign irq_ok    = i_ext_irq & i_mie & ~i_mret_e;
  assign sel_ill   = i_valid_e & i_illegal_e;
  assign sel_ecall = i_valid_e & i_ecall_e & ~i_illegal_e;
  assign sel_irq   = i_valid_e & irq_ok
                   & ~i_illegal_e & ~i_ecall_e;

  // One-hot selection of the winning request
  always_comb begin
    o_take  = 1'b0;
    o_cause = '0;
    unique case (1'b1)
      sel_ill: begin
        o_take       = 1'b1;
        o_cause[3:0] = CAUSE_ILLEGAL;
      end
      sel_ecall: begin
        o_take       = 1'b1;
        o_cause[3:0] = CAUSE_ECALL_M;
      end
      sel_irq: begin
        o_take         = 1'b1;
        o_cause[3:0]   = CAUSE_MEXT_IRQ;
        o_cause[XLEN-1] = 1'b1;
      end
      default: begin
        o_take  = 1'b0;
        o_cause = '0;
      end
    endcase
  end

endmodule

// File: rtl/trap_controller.sv
// Machine-mode trap entry sequencer.
// Squashes, drains, writes mepc/mcause, clears MIE, then vectors.
module trap_controller
  import trap_controller_pkg::*;
#(
  parameter int XLEN         = 32,
  parameter int DRAIN_CYCLES = 2
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_valid_e,
  input  logic            i_ecall_e,
  input  logic            i_illegal_e,
  input  logic            i_mret_e,
  input  logic            i_ext_irq,
  input  logic            i_mie,
  input  logic [XLEN-1:0] i_pc_e,
  input  logic [XLEN-1:0] i_mtvec,
  output logic            o_if_id_flush,
  output logic            o_id_ex_flush,
  output logic            o_ex_mem_flush,
  output logic            o_pc_stall,
  output logic            o_pc_redirect,
  output logic [XLEN-1:0] o_pc_target,
  output logic            o_csr_we,
  output logic [11:0]     o_csr_addr,
  output logic [XLEN-1:0] o_csr_wdata,
  output logic            o_mie_clear,
  output logic            o_busy
);

  localparam int CW =
    (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

  trap_state_e     state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [XLEN-1:0] epc_q, epc_d;
  logic [XLEN-1:0] cause_q, cause_d;

  logic            busy_q, busy_d;
  logic            hold_q, hold_d;
  logic            flush_q, flush_d;
  logic            redir_q, redir_d;
  logic            we_q, we_d;
  logic [11:0]     addr_q, addr_d;
  logic [XLEN-1:0] wdata_q, wdata_d;
  logic            mclr_q, mclr_d;

  logic            take;
  logic [XLEN-1:0] cause;
  logic            detect;

  trap_controller_cause_prio #(
    .XLEN(XLEN)
  ) u_prio (
    .i_valid_e  (i_valid_e),
    .i_ecall_e  (i_ecall_e),
    .i_illegal_e(i_illegal_e),
    .i_mret_e   (i_mret_e),
    .i_ext_irq  (i_ext_irq),
    .i_mie      (i_mie),
    .o_take     (take),
    .o_cause    (cause)
  );

  // Reset gating keeps the detect-cycle outputs low during reset
  assign detect = (state_q == TRAP_IDLE) & take & i_rst_n;

  // Next state, drain counter and captured trap context
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    epc_d   = epc_q;
    cause_d = cause_q;
    unique case (state_q)
      TRAP_IDLE: begin
        if (take) begin
          epc_d   = i_pc_e;
          cause_d = cause;
          cnt_d   = CW'(DRAIN_CYCLES - 1);
          state_d = TRAP_DRAIN;
        end
      end
      TRAP_DRAIN: begin
        if (cnt_q == '0) state_d = TRAP_WR_EPC;
        else             cnt_d   = cnt_q - CW'(1);
      end
      TRAP_WR_EPC:    state_d = TRAP_WR_CAUSE;
      TRAP_WR_CAUSE:  state_d = TRAP_WR_STATUS;
      TRAP_WR_STATUS: state_d = TRAP_REDIRECT;
      TRAP_REDIRECT:  state_d = TRAP_IDLE;
      default:        state_d = TRAP_IDLE;
    endcase
  end

  // Registered outputs decoded from the upcoming state
  always_comb begin
    busy_d  = (state_d != TRAP_IDLE);
    hold_d  = holds_pipe(state_d);
    redir_d = (state_d == TRAP_REDIRECT);
    flush_d = hold_d | redir_d;
    mclr_d  = (state_d == TRAP_WR_STATUS);
    we_d    = 1'b0;
    addr_d  = '0;
    wdata_d = '0;
    if (state_d == TRAP_WR_EPC) begin
      we_d    = 1'b1;
      addr_d  = CSR_MEPC;
      wdata_d = epc_d;
    end else if (state_d == TRAP_WR_CAUSE) begin
      we_d    = 1'b1;
      addr_d  = CSR_MCAUSE;
      wdata_d = cause_d;
    end
  end

  // Sequencer state, context and output registers
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= TRAP_IDLE;
      cnt_q   <= '0;
      epc_q   <= '0;
      cause_q <= '0;
      busy_q  <= 1'b0;
      hold_q  <= 1'b0;
      flush_q <= 1'b0;
      redir_q <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      mclr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      epc_q   <= epc_d;
      cause_q <= cause_d;
      busy_q  <= busy_d;
      hold_q  <= hold_d;
      flush_q <= flush_d;
      redir_q <= redir_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      mclr_q  <= mclr_d;
    end
  end

  assign o_if_id_flush  = flush_q | detect;
  assign o_id_ex_flush  = flush_q | detect;
  assign o_ex_mem_flush = detect;
  assign o_pc_stall     = hold_q | detect;
  assign o_pc_redirect  = redir_q;
  assign o_pc_target    = redir_q ? (i_mtvec & ~XLEN'(3)) : '0;
  assign o_csr_we       = we_q;
  assign o_csr_addr     = addr_q;
  assign o_csr_wdata    = wdata_q;
  assign o_mie_clear    = mclr_q;
  assign o_busy         = busy_q;

endmodule

// File: tb/tb_trap_controller.sv
// Directed bench for trap_controller.
// Hand-computed expectations per trap cycle.
module tb_trap_controller;

  logic        i_clk;
  logic        i_rst_n;
  logic        i_valid_e;
  logic        i_ecall_e;
  logic        i_illegal_e;
  logic        i_mret_e;
  logic        i_ext_irq;
  logic        i_mie;
  logic [31:0] i_pc_e;
  logic [31:0] i_mtvec;
  logic        o_if_id_flush;
  logic        o_id_ex_flush;
  logic        o_ex_mem_flush;
  logic        o_pc_stall;
  logic        o_pc_redirect;
  logic [31:0] o_pc_target;
  logic        o_csr_we;
  logic [11:0] o_csr_addr;
  logic [31:0] o_csr_wdata;
  logic        o_mie_clear;
  logic        o_busy;

  int n_cmp;
  int n_bad;
  int n_mepc;
  int n_mcause;

  logic [7:0]  ctl;
  logic [31:0] dat;

  // ctl = {ifid, idex, exmem, stall, redir, we, mclr, busy}
  localparam logic [7:0] C_IDLE   = 8'b0000_0000;
  localparam logic [7:0] C_DETECT = 8'b1111_0000;
  localparam logic [7:0] C_DRAIN  = 8'b1101_0001;
  localparam logic [7:0] C_WRITE  = 8'b1101_0101;
  localparam logic [7:0] C_STATUS = 8'b1101_0011;
  localparam logic [7:0] C_REDIR  = 8'b1100_1001;

  trap_controller #(
    .XLEN(32),
    .DRAIN_CYCLES(2)
  ) dut (
    .i_clk         (i_clk),
    .i_rst_n       (i_rst_n),
    .i_valid_e     (i_valid_e),
    .i_ecall_e     (i_ecall_e),
    .i_illegal_e   (i_illegal_e),
    .i_mret_e      (i_mret_e),
    .i_ext_irq     (i_ext_irq),
    .i_mie         (i_mie),
    .i_pc_e        (i_pc_e),
    .i_mtvec       (i_mtvec),
    .o_if_id_flush (o_if_id_flush),
    .o_id_ex_flush (o_id_ex_flush),
    .o_ex_mem_flush(o_ex_mem_flush),
    .o_pc_stall    (o_pc_stall),
    .o_pc_redirect (o_pc_redirect),
    .o_pc_target   (o_pc_target),
    .o_csr_we      (o_csr_we),
    .o_csr_addr    (o_csr_addr),
    .o_csr_wdata   (o_csr_wdata),
    .o_mie_clear   (o_mie_clear),
    .o_busy        (o_busy)
  );

  assign ctl = {o_if_id_flush, o_id_ex_flush,
                o_ex_mem_flush, o_pc_stall,
                o_pc_redirect, o_csr_we,
                o_mie_clear, o_busy};
  assign dat = o_pc_target | o_csr_wdata
             | {20'b0, o_csr_addr};

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // CSR write tally for the re-trigger test
  always @(negedge i_clk) begin
    if (i_rst_n && o_csr_we) begin
      if (o_csr_addr == 12'h341) n_mepc++;
      if (o_csr_addr == 12'h342) n_mcause++;
    end
  end

  task automatic chk(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h",
               tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic idle_in();
    i_valid_e   = 1'b0;
    i_ecall_e   = 1'b0;
    i_illegal_e = 1'b0;
    i_mret_e    = 1'b0;
    i_ext_irq   = 1'b0;
  endtask

  // Walks T+1..T+7 after a detect cycle
  task automatic run_seq(
    input string       tag,
    input logic [31:0] epc,
    input logic [31:0] cause,
    input logic [31:0] tgt,
    input bit          repulse
  );
    tick();
    idle_in();
    i_valid_e = repulse;
    i_ecall_e = repulse;
    @(negedge i_clk);
    chk({tag, "_drain1"}, {24'b0, ctl}, {24'b0, C_DRAIN});
    chk({tag, "_drain1_dat"}, dat, 32'h0);
    tick();
    idle_in();
    @(negedge i_clk);
    chk({tag, "_drain2"}, {24'b0, ctl}, {24'b0, C_DRAIN});
    tick();
    @(negedge i_clk);
    chk({tag, "_epc_ctl"}, {24'b0, ctl}, {24'b0, C_WRITE});
    chk({tag, "_epc_addr"}, {20'b0, o_csr_addr}, 32'h341);
    chk({tag, "_epc_data"}, o_csr_wdata, epc);
    tick();
    @(negedge i_clk);
    chk({tag, "_cause_ctl"}, {24'b0, ctl}, {24'b0, C_WRITE});
    chk({tag, "_cause_addr"}, {20'b0, o_csr_addr}, 32'h342);
    chk({tag, "_cause_data"}, o_csr_wdata, cause);
    tick();
    @(negedge i_clk);
    chk({tag, "_status"}, {24'b0, ctl}, {24'b0, C_STATUS});
    chk({tag, "_status_dat"}, dat, 32'h0);
    tick();
    @(negedge i_clk);
    chk({tag, "_redir"}, {24'b0, ctl}, {24'b0, C_REDIR});
    chk({tag, "_target"}, o_pc_target, tgt);
    tick();
    @(negedge i_clk);
    chk({tag, "_idle"}, {24'b0, ctl}, {24'b0, C_IDLE});
    chk({tag, "_idle_dat"}, dat, 32'h0);
  endtask

  initial begin
    int base_e;
    int base_c;
    n_cmp    = 0;
    n_bad    = 0;
    n_mepc   = 0;
    n_mcause = 0;
    i_rst_n  = 1'b0;
    idle_in();
    i_mie    = 1'b0;
    i_pc_e   = 32'h0;
    i_mtvec  = 32'h0;
    repeat (3) @(negedge i_clk);
    chk("rst_ctl", {24'b0, ctl}, {24'b0, C_IDLE});
    chk("rst_dat", dat, 32'h0);
    i_rst_n = 1'b1;
    tick();

    // 1: ECALL end to end
    i_valid_e = 1'b1;
    i_ecall_e = 1'b1;
    i_pc_e    = 32'h0000_0040;
    i_mtvec   = 32'h0000_0101;
    @(negedge i_clk);
    chk("t1_detect", {24'b0, ctl}, {24'b0, C_DETECT});
    run_seq("t1", 32'h40, 32'hB, 32'h100, 1'b0);

    // 2: illegal wins over ecall
    tick();
    i_valid_e   = 1'b1;
    i_ecall_e   = 1'b1;
    i_illegal_e = 1'b1;
    i_pc_e      = 32'h0000_1234;
    i_mtvec     = 32'h0200_0003;
    @(negedge i_clk);
    chk("t2_detect", {24'b0, ctl}, {24'b0, C_DETECT});
    run_seq("t2", 32'h1234, 32'h2, 32'h0200_0000, 1'b0);

    // 3: MRET masks irq, next cycle irq is taken
    tick();
    i_valid_e = 1'b1;
    i_mret_e  = 1'b1;
    i_ext_irq = 1'b1;
    i_mie     = 1'b1;
    i_pc_e    = 32'h0000_0500;
    i_mtvec   = 32'h0000_0080;
    @(negedge i_clk);
    chk("t3_mret", {24'b0, ctl}, {24'b0, C_IDLE});
    tick();
    i_mret_e = 1'b0;
    i_pc_e   = 32'h0000_0504;
    @(negedge i_clk);
    chk("t3_detect", {24'b0, ctl}, {24'b0, C_DETECT});
    run_seq("t3", 32'h504, 32'h8000_000B, 32'h80, 1'b0);
    i_mie = 1'b0;

    // 4: masked interrupt never starts a trap
    tick();
    i_valid_e = 1'b1;
    i_ext_irq = 1'b1;
    i_mie     = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge i_clk);
      chk("t4_ctl", {24'b0, ctl}, {24'b0, C_IDLE});
      chk("t4_dat", dat, 32'h0);
      tick();
    end
    idle_in();

    // 5: ECALL re-pulsed during DRAIN is ignored
    base_e    = n_mepc;
    base_c    = n_mcause;
    i_valid_e = 1'b1;
    i_ecall_e = 1'b1;
    i_pc_e    = 32'h0000_0900;
    i_mtvec   = 32'h0000_0400;
    @(negedge i_clk);
    chk("t5_detect", {24'b0, ctl}, {24'b0, C_DETECT});
    run_seq("t5", 32'h900, 32'hB, 32'h400, 1'b1);
    chk("t5_n_mepc", n_mepc - base_e, 1);
    chk("t5_n_mcause", n_mcause - base_c, 1);

    // 6: async reset in WR_CAUSE
    tick();
    i_valid_e = 1'b1;
    i_ecall_e = 1'b1;
    i_pc_e    = 32'h0000_0C00;
    @(negedge i_clk);
    chk("t6_detect", {24'b0, ctl}, {24'b0, C_DETECT});
    tick();
    idle_in();
    repeat (3) tick();
    @(negedge i_clk);
    chk("t6_wrcause", {20'b0, o_csr_addr}, 32'h342);
    #2;
    i_rst_n = 1'b0;
    #1;
    chk("t6_rst_ctl", {24'b0, ctl}, {24'b0, C_IDLE});
    chk("t6_rst_dat", dat, 32'h0);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    tick();
    @(negedge i_clk);
    chk("t6_post_busy", {31'b0, o_busy}, 32'h0);
    chk("t6_post_ctl", {24'b0, ctl}, {24'b0, C_IDLE});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
